sequenciador_leds: RTL and testbench

- Controller that plays the stored round sequence back on the board LEDs before the player's turn.
- Steps a memory address from 0 to a round limit, fetches each 8-bit LED pattern, and lights it for an on-time followed by a dark gap.
- Signals completion to the main control unit, which then enables the play phase.
- Sits beside the control unit and drives the datapath's memory address and LED outputs during the "show" phase.

---
 rtl/sequenciador_leds.sv | 135 +++++++++++++
 tb/tb_sequenciador_leds.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_leds.sv
// Show-phase controller: plays stored LED patterns from address 0 up to a latched
// limit, each lit for Ton cycles followed by a Toff dark gap, then pulses pronto.
module sequenciador_leds #(
  parameter int ADDR_W  = 4,
  parameter int T_ON    = 1000,
  parameter int T_OFF   = 500,
  parameter int TIMER_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic              dificuldade,
  input  logic [ADDR_W-1:0] limite,
  input  logic [7:0]        dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [7:0]        leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } t_estado;

  // Terminal timer values (duration minus one) for each difficulty.
  localparam logic [TIMER_W-1:0] ON_NORMAL  = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] ON_RAPIDO  = TIMER_W'(T_ON / 2 - 1);
  localparam logic [TIMER_W-1:0] OFF_NORMAL = TIMER_W'(T_OFF - 1);
  localparam logic [TIMER_W-1:0] OFF_RAPIDO = TIMER_W'(T_OFF / 2 - 1);

  t_estado             r_estado;
  t_estado             w_prox;
  logic [TIMER_W-1:0]  r_timer;
  logic [ADDR_W-1:0]   r_limite;
  logic                r_dificuldade;
  logic [ADDR_W-1:0]   r_endereco;
  logic [7:0]          r_leds;
  logic                r_ocupado;
  logic                r_pronto;
  logic                w_fim_on;
  logic                w_fim_off;
  logic                w_ultimo;

  assign w_fim_on  = (r_timer == (r_dificuldade ? ON_RAPIDO : ON_NORMAL));
  assign w_fim_off = (r_timer == (r_dificuldade ? OFF_RAPIDO : OFF_NORMAL));
  assign w_ultimo  = (r_endereco == r_limite);

  // Next-state logic; abortar overrides every other condition.
  always_comb begin
    w_prox = r_estado;
    if (abortar) begin
      w_prox = OCIOSO;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) w_prox = BUSCA;
          else         w_prox = OCIOSO;
        end
        BUSCA: w_prox = ACESO;
        ACESO: begin
          if (w_fim_on) w_prox = APAGADO;
          else          w_prox = ACESO;
        end
        APAGADO: begin
          if (!w_fim_off)    w_prox = APAGADO;
          else if (w_ultimo) w_prox = FIM;
          else               w_prox = BUSCA;
        end
        FIM:     w_prox = OCIOSO;
        default: w_prox = OCIOSO;
      endcase
    end
  end

  // State, timer and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado      <= OCIOSO;
      r_timer       <= '0;
      r_limite      <= '0;
      r_dificuldade <= 1'b0;
      r_endereco    <= '0;
      r_leds        <= 8'h00;
      r_ocupado     <= 1'b0;
      r_pronto      <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_ocupado <= (w_prox != OCIOSO);
      r_pronto  <= (w_prox == FIM);
      // Timer runs only while staying in a timed state; any transition clears it.
      if ((r_estado == ACESO || r_estado == APAGADO) && (w_prox == r_estado))
        r_timer <= r_timer + TIMER_W'(1);
      else
        r_timer <= '0;

      if (abortar) begin
        if (r_estado != OCIOSO) begin
          r_endereco <= '0;
          r_leds     <= 8'h00;
        end
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (iniciar) begin
              r_limite      <= limite;
              r_dificuldade <= dificuldade;
              r_endereco    <= '0;
            end
          end
          BUSCA: r_leds <= dado_memoria;
          ACESO: begin
            if (w_fim_on) r_leds <= 8'h00;
          end
          APAGADO: begin
            if (w_fim_off && !w_ultimo) r_endereco <= r_endereco + ADDR_W'(1);
          end
          default: r_leds <= r_leds;
        endcase
      end
    end
  end

  assign endereco  = r_endereco;
  assign leds      = r_leds;
  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign db_estado = {1'b0, r_estado};

endmodule

// File: tb/tb_sequenciador_leds.sv
// Directed bench: instance A (T_ON=4, T_OFF=2) and instance B (T_ON=2, T_OFF=2),
// each reading from its own combinational memory model.
module tb_sequenciador_leds;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ini_a = 1'b0;
  logic       ini_b = 1'b0;
  logic       abortar = 1'b0;
  logic       dificuldade = 1'b0;
  logic [3:0] limite = 4'd0;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  logic [3:0] end_a, end_b, est_a, est_b;
  logic [7:0] leds_a, leds_b, dado_a, dado_b;
  logic       oc_a, oc_b, pr_a, pr_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign dado_a = mem_a[end_a];
  assign dado_b = mem_b[end_b];

  sequenciador_leds #(.ADDR_W(4), .T_ON(4), .T_OFF(2), .TIMER_W(16)) dut_a (
    .clock(clock), .reset(reset), .iniciar(ini_a), .abortar(abortar),
    .dificuldade(dificuldade), .limite(limite), .dado_memoria(dado_a),
    .endereco(end_a), .leds(leds_a), .ocupado(oc_a), .pronto(pr_a), .db_estado(est_a));

  sequenciador_leds #(.ADDR_W(4), .T_ON(2), .T_OFF(2), .TIMER_W(16)) dut_b (
    .clock(clock), .reset(reset), .iniciar(ini_b), .abortar(abortar),
    .dificuldade(dificuldade), .limite(limite), .dado_memoria(dado_b),
    .endereco(end_b), .leds(leds_b), .ocupado(oc_b), .pronto(pr_b), .db_estado(est_b));

  // Packed observation vector: {estado, endereco, leds, pronto, ocupado}
  function automatic logic [17:0] obs(bit sel_b);
    if (sel_b) return {est_b, end_b, leds_b, pr_b, oc_b};
    else       return {est_a, end_a, leds_a, pr_a, oc_a};
  endfunction

  // Expected outputs in cycle c of a run from the published timing formulas.
  function automatic logic [17:0] modelo(int c, int ton, int toff, int lim, bit sel_b);
    int p, i, r;
    logic [3:0] est, endr;
    logic [7:0] lz;
    logic pr, oc;
    p = 1 + ton + toff;
    est = 4'd0; endr = 4'd0; lz = 8'h00; pr = 1'b0; oc = 1'b0;
    if (c <= (lim + 1) * p) begin
      i = (c - 1) / p;
      r = (c - 1) % p;
      endr = 4'(i);
      oc = 1'b1;
      if (r == 0) est = 4'd1;
      else if (r <= ton) begin
        est = 4'd2;
        lz = sel_b ? mem_b[i] : mem_a[i];
      end else est = 4'd3;
    end else if (c == (lim + 1) * p + 1) begin
      est = 4'd4; endr = 4'(lim); pr = 1'b1; oc = 1'b1;
    end else begin
      endr = 4'(lim);
    end
    return {est, endr, lz, pr, oc};
  endfunction

  task automatic check(string nome, int c, logic [17:0] got, logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got={est=%0d end=%0d leds=%h pr=%b oc=%b} exp={est=%0d end=%0d leds=%h pr=%b oc=%b}",
               nome, c, got[17:14], got[13:10], got[9:2], got[1], got[0],
               exp[17:14], exp[13:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic inicia(bit sel_b);
    if (sel_b) ini_b = 1'b1;
    else       ini_a = 1'b1;
    step();
    ini_a = 1'b0;
    ini_b = 1'b0;
  endtask

  task automatic run_trace(string nome, int c0, int c1, int ton, int toff, int lim, bit sel_b);
    for (int c = c0; c <= c1; c++) begin
      check(nome, c, obs(sel_b), modelo(c, ton, toff, lim, sel_b));
      step();
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] est;
    logic [3:0] endr;
    logic [7:0] lz;
    logic       pr;
    logic       oc;
  } vec_t;

  vec_t tab [9];

  initial begin
    // Single-element run, T_ON=4, T_OFF=2, hand-written trace.
    tab[0] = '{1, 4'd1, 4'd0, 8'h00, 1'b0, 1'b1};
    tab[1] = '{2, 4'd2, 4'd0, 8'h01, 1'b0, 1'b1};
    tab[2] = '{3, 4'd2, 4'd0, 8'h01, 1'b0, 1'b1};
    tab[3] = '{4, 4'd2, 4'd0, 8'h01, 1'b0, 1'b1};
    tab[4] = '{5, 4'd2, 4'd0, 8'h01, 1'b0, 1'b1};
    tab[5] = '{6, 4'd3, 4'd0, 8'h00, 1'b0, 1'b1};
    tab[6] = '{7, 4'd3, 4'd0, 8'h00, 1'b0, 1'b1};
    tab[7] = '{8, 4'd4, 4'd0, 8'h00, 1'b1, 1'b1};
    tab[8] = '{9, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'(8'h11 * i + 8'h03);
    end
    mem_a[0] = 8'h01; mem_a[1] = 8'h10; mem_a[2] = 8'h80;
    mem_b[5] = 8'h00;

    step(); step();
    reset = 1'b0;
    check("reset_a", 0, obs(1'b0), 18'd0);
    check("reset_b", 0, obs(1'b1), 18'd0);

    // Test 1: table-driven single element
    limite = 4'd0;
    inicia(1'b0);
    for (int k = 0; k < 9; k++) begin
      check("t1_table", tab[k].cyc, obs(1'b0),
            {tab[k].est, tab[k].endr, tab[k].lz, tab[k].pr, tab[k].oc});
      step();
    end

    // Test 2: three elements, pronto at cycle 22
    limite = 4'd2;
    inicia(1'b0);
    run_trace("t2_seq", 1, 23, 4, 2, 2, 1'b0);

    // Test 3: fast mode, limit 1; inputs changed mid-run must not matter
    dificuldade = 1'b1;
    limite = 4'd1;
    inicia(1'b0);
    run_trace("t3_fast", 1, 2, 2, 1, 1, 1'b0);
    dificuldade = 1'b0;
    limite = 4'd3;
    run_trace("t3_fast", 3, 10, 2, 1, 1, 1'b0);

    // Test 4: abort during ACESO in cycle 4
    limite = 4'd2;
    inicia(1'b0);
    run_trace("t4_pre", 1, 3, 4, 2, 2, 1'b0);
    check("t4_pre", 4, obs(1'b0), modelo(4, 4, 2, 2, 1'b0));
    abortar = 1'b1;
    step();
    abortar = 1'b0;
    check("t4_abort", 5, obs(1'b0), 18'd0);
    for (int c = 6; c < 16; c++) begin
      step();
      check("t4_no_pronto", c, obs(1'b0), 18'd0);
    end
    abortar = 1'b1;
    ini_a = 1'b1;
    step();
    abortar = 1'b0;
    ini_a = 1'b0;
    check("t4_abort_wins", 0, obs(1'b0), 18'd0);
    step();
    check("t4_abort_wins2", 0, obs(1'b0), 18'd0);
    inicia(1'b0);
    run_trace("t4_restart", 1, 3, 4, 2, 2, 1'b0);
    abortar = 1'b1;
    step();
    abortar = 1'b0;

    // Test 5: ignored iniciar mid-run, then reset in APAGADO of element 1
    inicia(1'b0);
    run_trace("t5_run", 1, 3, 4, 2, 2, 1'b0);
    ini_a = 1'b1;
    run_trace("t5_run", 4, 4, 4, 2, 2, 1'b0);
    ini_a = 1'b0;
    run_trace("t5_run", 5, 13, 4, 2, 2, 1'b0);
    check("t5_apagado", 14, obs(1'b0), modelo(14, 4, 2, 2, 1'b0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_reset", 15, obs(1'b0), 18'd0);

    // Test 6: full address range on instance B, pronto at cycle 81
    limite = 4'd15;
    inicia(1'b1);
    run_trace("t6_full", 1, 82, 2, 2, 15, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
